inst_mem_loader: RTL and testbench
==================================

Name: inst_mem_loader

Overview:
- Boot-load controller between the UART RX byte stream and the 8-bit-wide instruction memory.
- Parses a framed download: SYNC, LEN, BASE, LEN data bytes, then an optional checksum byte.
- Issues one registered memory write per data byte.
- Holds the CPU in reset until a frame completes cleanly.

Parameters:
- ADDR_W, 8, instruction memory address width (depth 2^ADDR_W bytes).
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1000000, maximum idle clk cycles between bytes inside a frame before abort; minimum 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- rx_data  in  8  byte from UART RX; valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe, byte available.
- mem_we  out  1  one-cycle write strobe to instruction memory.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  8  write data.
- cpu_hold  out  1  1 = keep CPU in reset.
- load_done  out  1  1 = last frame completed successfully.
- load_err  out  1  1 = last frame aborted (bad length, checksum or timeout).
- byte_count  out  8  data bytes written in the current or last frame.

Behaviour:
- Reset values:
  - mem_we=0, mem_addr=0, mem_wdata=0, byte_count=0.
  - cpu_hold=1, load_done=0, load_err=0, state=IDLE, timeout counter=0.
- Reset mid-frame:
  - All of the above take their reset values immediately.
  - Memory contents already written are not cleared.
- States: IDLE, LEN, BASE, DATA, CKSUM, DONE, ERR. Transitions occur only on rx_valid, except the timeout.
- IDLE/DONE/ERR:
  - rx_valid with rx_data==SYNC_BYTE -> LEN; cpu_hold=1, load_done=0, load_err=0, byte_count=0.
  - Any other byte is ignored.
- LEN: store len=rx_data.
  - len==0 -> ERR.
  - Otherwise -> BASE.
- BASE: store addr pointer=rx_data[ADDR_W-1:0] (upper bits discarded if ADDR_W<8; zero-extended if ADDR_W>8) -> DATA.
- DATA, each rx_valid:
  - Next cycle: mem_we=1, mem_addr=pointer, mem_wdata=rx_data. Latency exactly 1 cycle; mem_we is high for exactly one cycle.
  - Pointer increments modulo 2^ADDR_W (wraps 8'hFF -> 8'h00 when ADDR_W=8).
  - byte_count increments.
  - XOR accumulator ^= rx_data.
  - After the len-th byte -> CKSUM (if LOADER_CKSUM_EN) else DONE.
- CKSUM:
  - rx_data==accumulator -> DONE.
  - Mismatch -> ERR.
  - The checksum byte is never written to memory.
- DONE: cpu_hold=0, load_done=1.
- ERR: cpu_hold=1, load_err=1.
- Timeout:
  - In LEN/BASE/DATA/CKSUM, the counter increments each cycle without rx_valid and clears on rx_valid.
  - Reaching TIMEOUT_CYCLES -> ERR.
  - If rx_valid arrives in the same cycle the counter would expire, the byte wins and the counter clears.
- A SYNC_BYTE value received inside LEN/BASE/DATA/CKSUM is treated as ordinary data, not a restart.
- load_done and load_err are never both 1.

Optional Feature:
- Macro: LOADER_CKSUM_EN.
- Defined:
  - Frame carries a trailing checksum byte equal to the XOR of all data bytes; CKSUM state present.
  - Mismatch -> ERR with cpu_hold=1.
- Undefined:
  - No CKSUM state and no accumulator logic.
  - DONE is entered the cycle after the last data byte is accepted.
  - The byte following the frame is handled as in DONE (ignored unless SYNC_BYTE).

Test Plan:
- Basic load:
  - Stimulus: rst, then A5, 03, 10, 11, 22, 33 (+ cksum 00 if enabled).
  - Response: writes (10,11), (11,22), (12,33), each mem_we one cycle after its rx_valid.
  - Then load_done=1, cpu_hold=0, byte_count=3.
- Address wrap:
  - Stimulus: A5, 02, FF, AA, BB (+ cksum 11).
  - Response: writes at FF then 00.
- Bad checksum (enabled):
  - Stimulus: A5, 01, 00, 5A, 5B.
  - Response: write at 00 occurs; load_err=1, cpu_hold=1, load_done=0.
- Zero length and timeout:
  - A5, 00 -> load_err=1.
  - TIMEOUT_CYCLES=16: A5, 02, 00, 01, then idle 16 cycles -> load_err=1. A byte on the 16th cycle instead must prevent the error.
- Reset mid-frame and reload:
  - Stimulus: rst after 2 data bytes of a 4-byte frame.
  - Response: all outputs return to reset values.
  - A subsequent full frame completes with byte_count=4 and load_done=1.
- Non-sync in IDLE/DONE:
  - Stimulus: bytes 00, FF, 12.
  - Response: no mem_we; state and flags unchanged.

Source files
------------

// File: rtl/inst_mem_loader_if.sv
// Byte-stream and memory-write bus for the instruction memory boot loader.
// master: the loader side (consumes UART RX bytes, drives the memory port).
// slave:  the environment side (supplies RX bytes, receives memory writes).
interface inst_mem_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    modport master (
        input  rx_data,
        input  rx_valid,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/inst_mem_loader.sv
// Boot-load controller: parses SYNC, LEN, BASE, LEN data bytes (and an
// optional XOR checksum byte) from the UART RX stream, writes each data byte
// into instruction memory one cycle after it arrives, and keeps the CPU in
// reset until a frame completes cleanly.
// Optional feature macro: LOADER_CKSUM_EN (trailing checksum byte + CKSUM state).
module inst_mem_loader #(
    parameter int         ADDR_W         = 8,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    inst_mem_loader_if.master bus,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [7:0]        byte_count
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_BASE,
        S_DATA,
`ifdef LOADER_CKSUM_EN
        S_CKSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [7:0]        len_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [TW-1:0]     tmo_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic [7:0]        cnt_q;
`ifdef LOADER_CKSUM_EN
    logic [7:0]        acc_q;
`endif

    logic in_frame;
    logic start_frame;
    logic take_data;
    logic last_byte;
    logic tmo_hit;

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign byte_count    = cnt_q;

    // Next-state decode, per-byte control strobes and the Moore status flags.
    always_comb begin
        state_d     = state_q;
        in_frame    = 1'b0;
        start_frame = 1'b0;
        cpu_hold    = 1'b1;
        load_done   = 1'b0;
        load_err    = 1'b0;
        take_data   = (state_q == S_DATA) && bus.rx_valid;
        last_byte   = take_data && ((cnt_q + 8'd1) == len_q);

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
                    start_frame = 1'b1;
                    state_d     = S_LEN;
                end
            end
            S_LEN: begin
                in_frame = 1'b1;
                if (bus.rx_valid) begin
                    state_d = (bus.rx_data == 8'h00) ? S_ERR : S_BASE;
                end
            end
            S_BASE: begin
                in_frame = 1'b1;
                if (bus.rx_valid) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                in_frame = 1'b1;
                if (last_byte) begin
`ifdef LOADER_CKSUM_EN
                    state_d = S_CKSUM;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef LOADER_CKSUM_EN
            S_CKSUM: begin
                in_frame = 1'b1;
                if (bus.rx_valid) begin
                    state_d = (bus.rx_data == acc_q) ? S_DONE : S_ERR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        tmo_hit = in_frame && !bus.rx_valid && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
        if (tmo_hit) begin
            state_d = S_ERR;
        end

        if (state_q == S_DONE) begin
            cpu_hold  = 1'b0;
            load_done = 1'b1;
        end
        if (state_q == S_ERR) begin
            load_err = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Inter-byte idle counter; only runs while a frame is open and a byte restarts it.
    always_ff @(posedge clk) begin
        if (rst || !in_frame || bus.rx_valid || tmo_hit) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TW'(1);
        end
    end

    // Frame header capture, write pointer and the registered memory write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
            cnt_q       <= 8'h00;
            len_q       <= 8'h00;
            ptr_q       <= '0;
        end else begin
            mem_we_q <= take_data;
            if (start_frame) begin
                cnt_q <= 8'h00;
            end
            if ((state_q == S_LEN) && bus.rx_valid) begin
                len_q <= bus.rx_data;
            end
            if ((state_q == S_BASE) && bus.rx_valid) begin
                ptr_q <= ADDR_W'(bus.rx_data);
            end
            if (take_data) begin
                mem_addr_q  <= ptr_q;
                mem_wdata_q <= bus.rx_data;
                ptr_q       <= ptr_q + ADDR_W'(1);
                cnt_q       <= cnt_q + 8'd1;
            end
        end
    end

`ifdef LOADER_CKSUM_EN
    // Running XOR of the data bytes of the open frame.
    always_ff @(posedge clk) begin
        if (rst || start_frame) begin
            acc_q <= 8'h00;
        end else if (take_data) begin
            acc_q <= acc_q ^ bus.rx_data;
        end
    end
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader. Frames are built at frame level;
// the expected memory writes go into a scoreboard queue checked by a monitor,
// the expected end-of-frame status is derived from the frame contents.
`timescale 1ns/1ps
module tb_inst_mem_loader;
    localparam int ADDR_W = 8;
    localparam int TMO    = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cpu_hold;
    logic       load_done;
    logic       load_err;
    logic [7:0] byte_count;

    inst_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    inst_mem_loader #(
        .ADDR_W(ADDR_W),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .cpu_hold(cpu_hold),
        .load_done(load_done),
        .load_err(load_err),
        .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         edge_no;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_w;
    wr_t        push_w;
    logic [7:0] frame_data[$];
    int         edge_no = 0;
    int         last_edge = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    always @(posedge clk) edge_no <= edge_no + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every memory write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (load_done || load_err) begin
                checkOutput("done_err_exclusive", {31'd0, load_done & load_err}, 32'd0);
            end
            if (bus.mem_we === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                             bus.mem_addr, bus.mem_wdata);
                end else begin
                    mon_w = exp_q.pop_front();
                    if (bus.mem_addr !== mon_w.addr || bus.mem_wdata !== mon_w.data ||
                        edge_no != mon_w.edge_no) begin
                        n_fail++;
                        $display("[TB] FAIL write: got addr 0x%0h data 0x%0h edge %0d, expected addr 0x%0h data 0x%0h edge %0d",
                                 bus.mem_addr, bus.mem_wdata, edge_no, mon_w.addr, mon_w.data, mon_w.edge_no);
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
        last_edge    = edge_no;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expectWrite(input logic [7:0] a, input logic [7:0] d);
        push_w.addr    = a;
        push_w.data    = d;
        push_w.edge_no = last_edge;
        exp_q.push_back(push_w);
    endtask

    task automatic checkStatus(input bit done, input logic [7:0] bc);
        checkOutput("load_done", {31'd0, load_done}, {31'd0, done});
        checkOutput("load_err", {31'd0, load_err}, {31'd0, !done});
        checkOutput("cpu_hold", {31'd0, cpu_hold}, {31'd0, !done});
        checkOutput("byte_count", {24'd0, byte_count}, {24'd0, bc});
    endtask

    task automatic doReset();
        rst = 1'b1;
        idleCycles(2);
        rst = 1'b0;
        checkOutput("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        checkOutput("rst_mem_addr", {24'd0, bus.mem_addr}, 32'd0);
        checkOutput("rst_mem_wdata", {24'd0, bus.mem_wdata}, 32'd0);
        checkOutput("rst_byte_count", {24'd0, byte_count}, 32'd0);
        checkOutput("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        checkOutput("rst_load_done", {31'd0, load_done}, 32'd0);
        checkOutput("rst_load_err", {31'd0, load_err}, 32'd0);
    endtask

    // Sends one frame built from frame_data and checks the resulting status.
    task automatic sendFrame(input int len, input logic [7:0] base, input bit good_ck, input int max_gap);
        logic [7:0] x;
        bit         exp_done;
        x = 8'h00;
        applyStimulus(8'hA5);
        idleCycles($urandom_range(0, max_gap));
        applyStimulus(8'(len));
        if (len == 0) begin
            idleCycles(2);
            checkStatus(1'b0, 8'd0);
            return;
        end
        idleCycles($urandom_range(0, max_gap));
        applyStimulus(base);
        for (int i = 0; i < len; i++) begin
            idleCycles($urandom_range(0, max_gap));
            applyStimulus(frame_data[i]);
            expectWrite(base + 8'(i), frame_data[i]);
            x = x ^ frame_data[i];
        end
`ifdef LOADER_CKSUM_EN
        idleCycles($urandom_range(0, max_gap));
        applyStimulus(good_ck ? x : (x ^ 8'h01));
        exp_done = good_ck;
`else
        exp_done = 1'b1;
`endif
        idleCycles(2);
        checkStatus(exp_done, 8'(len));
    endtask

    initial begin
        int         len;
        logic [7:0] d;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        doReset();

        // Basic load.
        frame_data = '{8'h11, 8'h22, 8'h33};
        sendFrame(3, 8'h10, 1'b1, 0);

        // Stray bytes after a completed frame change nothing.
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        idleCycles(1);
        applyStimulus(8'h12);
        idleCycles(2);
        checkStatus(1'b1, 8'd3);

        // Address wrap.
        frame_data = '{8'hAA, 8'hBB};
        sendFrame(2, 8'hFF, 1'b1, 1);

`ifdef LOADER_CKSUM_EN
        // Bad checksum.
        frame_data = '{8'h5A};
        sendFrame(1, 8'h00, 1'b0, 0);
`endif

        // Zero length, then stray bytes in the error state.
        sendFrame(0, 8'h00, 1'b1, 0);
        applyStimulus(8'h00);
        applyStimulus(8'h12);
        idleCycles(2);
        checkStatus(1'b0, 8'd0);

        // Timeout after 16 idle cycles inside the data phase.
        applyStimulus(8'hA5);
        applyStimulus(8'h02);
        applyStimulus(8'h00);
        applyStimulus(8'h01);
        expectWrite(8'h00, 8'h01);
        idleCycles(TMO - 1);
        checkOutput("tmo_not_yet", {31'd0, load_err}, 32'd0);
        idleCycles(1);
        checkStatus(1'b0, 8'd1);

        // A byte on the 16th idle cycle keeps the frame alive.
        applyStimulus(8'hA5);
        applyStimulus(8'h02);
        applyStimulus(8'h00);
        applyStimulus(8'h01);
        expectWrite(8'h00, 8'h01);
        idleCycles(TMO - 1);
        applyStimulus(8'h02);
        expectWrite(8'h01, 8'h02);
`ifdef LOADER_CKSUM_EN
        applyStimulus(8'h03);
`endif
        idleCycles(2);
        checkStatus(1'b1, 8'd2);

        // Reset mid-frame, then a clean reload.
        applyStimulus(8'hA5);
        applyStimulus(8'h04);
        applyStimulus(8'h20);
        applyStimulus(8'hC1);
        expectWrite(8'h20, 8'hC1);
        applyStimulus(8'hC2);
        expectWrite(8'h21, 8'hC2);
        idleCycles(2);
        doReset();
        frame_data = '{8'hA5, 8'h01, 8'h02, 8'h03};
        sendFrame(4, 8'h30, 1'b1, 2);

        // Randomized frames with noise between them.
        for (int f = 0; f < 25; f++) begin
            len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
            frame_data.delete();
            for (int i = 0; i < len; i++) begin
                d = ($urandom_range(0, 4) == 0) ? 8'hA5 : 8'($urandom);
                frame_data.push_back(d);
            end
            sendFrame(len, 8'($urandom), $urandom_range(0, 4) != 0, 3);
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                d = 8'($urandom);
                if (d == 8'hA5) d = 8'h00;
                applyStimulus(d);
            end
        end

        idleCycles(3);
        checkOutput("pending_writes", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
